seg_scan_n: RTL and testbench
=============================

Name: seg_scan_n

Overview:
Parametrised multiplexed seven-segment driver for N digits.
- Periodically samples a binary input word.
- Displays it as hex, or as decimal using a multi-cycle sequential double-dabble converter.
- Supports per-digit decimal points, leading-zero blanking and overflow indication.
- Sits between application status registers (e.g. the SDRAM test error/pass counters) and the board's common-anode display pins.

Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- DATA_W, 16: input word width; must satisfy DATA_W <= 4*DIGITS.
- SCAN_DIV, 65536: clk_24m cycles each digit is enabled.
- UPDATE_DIV, 2400000: clk_24m cycles between input samples (0.1 s).
- SEG_ACT_LOW, 1: 1 = segment lines are active-low.
- DIG_ACT_LOW, 1: 1 = digit enables are active-low.

Ports:
- clk_24m  in  1  system clock, 24 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- data_in  in  DATA_W  value to display; sampled on the update tick.
- mode  in  1  0 = hex, 1 = decimal; sampled together with data_in.
- dp_in  in  DIGITS  decimal-point request per digit; bit 0 = rightmost digit.
- blank_lz  in  1  1 = blank leading zeros.
- seg  out  8  segment pattern {dp,g,f,e,d,c,b,a}.
- dig  out  DIGITS  digit enables, one-hot in the active polarity.
- busy  out  1  decimal conversion in progress.
- overflow  out  1  decimal value >= 10^DIGITS; held until the next commit.

Behaviour:
- Reset (asynchronous, active-low, clock clk_24m):
  - seg = all segments off (8'hFF when active-low).
  - dig = all digits off.
  - busy = 0, overflow = 0.
  - Display register = all zeros; scan index = 0; both dividers = 0.
  - Reset asserted mid-conversion aborts it immediately; no partial commit occurs.
- Update tick:
  - The update counter counts 0..UPDATE_DIV-1 and wraps; the tick is asserted when the count equals UPDATE_DIV-1.
  - On the tick, data_in and mode are latched.
  - A tick that occurs while busy=1 is ignored.
- Hex path (mode = 0):
  - Nibble k of the zero-extended data drives digit k.
  - Commit to the display register occurs one cycle after the tick.
  - overflow is cleared.
- Decimal path (mode = 1):
  - The sub-converter starts the cycle after the tick.
  - busy is high for exactly DATA_W+1 cycles: DATA_W shift/add-3 cycles, then one commit cycle.
  - busy falls in the same cycle the display register updates.
  - If the result needs more than DIGITS BCD digits: overflow = 1 and every digit shows a dash (segment g only).
  - Otherwise overflow = 0.
- Display register:
  - Updated atomically, so the scan never shows a mixture of old and new digits.
- Scan:
  - The digit index advances every SCAN_DIV cycles, runs 0..DIGITS-1 and wraps to 0.
  - seg and dig are registered and change in the same cycle.
- Font (active-low values):
  - 0..9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - A..F: 88 83 C6 A1 86 8E.
  - Dash: BF. Blank: FF.
- Decimal point: dp_in[k] clears bit 7 (active) while digit k is shown. It applies to blanked digits too.
- Leading-zero blanking (blank_lz = 1): every digit above the most significant non-zero digit is blanked. Digit 0 is never blanked, so a value of 0 shows a single "0". Blanking does not apply to dash/overflow display.
- Polarity: when SEG_ACT_LOW = 0 the seg output is bitwise inverted; when DIG_ACT_LOW = 0 the dig output is bitwise inverted.
- mode, dp_in and blank_lz changes take effect on the scan path within one cycle, except mode, which takes effect only at the next tick.

Decomposition:
- Package seg_pkg: 16-entry font constant array, SEG_BLANK and SEG_DASH constants, and a digit-count function clog2.
- Sub-module bcd_seq_conv (DATA_W, DIGITS):
  - Ports: start, bin, done, bcd[4*DIGITS-1:0], ovf.
  - Implements sequential double-dabble, one bit per cycle.
  - ovf is set if a carry leaves the top BCD digit or any shifted-out bit is non-zero.
  - Replaces the combinational bin2bcd loop.

Test Plan:
Bench parameters: DIGITS=4, DATA_W=16, SCAN_DIV=4, UPDATE_DIV=64.
1. Hold rst_n low -> seg = 8'hFF, dig = 4'hF, busy = 0, overflow = 0. Release -> dig cycles 1110, 1101, 1011, 0111 every 4 cycles, seg = C0.
2. mode=0, data_in=16'h1A3F, one tick -> next cycle display commits; digits 0..3 show 8E, B0, 88, F9.
3. mode=1, data_in=1234 -> busy high 17 cycles after the tick; digits 0..3 show 99, B0, A4, F9; overflow = 0.
4. mode=1, data_in=12345 -> overflow = 1; all digits BF. Next tick with data_in=42 -> overflow = 0; digits show A4 99 C0 C0.
5. blank_lz=1, mode=1:
   - data_in=7 -> digit 0 = F8, digits 1..3 = FF.
   - data_in=0 -> digit 0 = C0, others FF.
   - Adding dp_in=4'b0100 -> digit 2 = 7F.
6. Assert rst_n during busy (conversion cycle 5) -> busy = 0 immediately; display all C0 after release; no stale commit.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - font table, update state type and sizing helper for the segment scanner
package seg_pkg;

  // Active-low patterns {dp,g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [7:0] SEG_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {ST_IDLE, ST_HEX, ST_DEC} upd_state_e;

  // Ceiling log2, never below 1 so the result can size a counter directly.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential double-dabble, one input bit per cycle
module bcd_seq_conv
  import seg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk_24m,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = clog2(DATA_W + 1);

  logic [BCD_W-1:0]  r_bcd;
  logic [DATA_W-1:0] r_bin;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_run;
  logic              r_done;
  logic              r_ovf;

  logic [BCD_W-1:0]  w_src_bcd;
  logic [DATA_W-1:0] w_src_bin;
  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_nbcd;
  logic [DATA_W-1:0] w_nbin;
  logic              w_carry;

  // The start cycle already performs the first shift, straight from bin.
  always_comb begin
    w_src_bcd = start ? '0 : r_bcd;
    w_src_bin = start ? bin : r_bin;
    w_adj     = w_src_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_src_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = w_src_bcd[4*k +: 4] + 4'd3;
    end
  end

  assign w_carry = w_adj[BCD_W-1];
  assign w_nbcd  = {w_adj[BCD_W-2:0], w_src_bin[DATA_W-1]};
  assign w_nbin  = w_src_bin << 1;

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd  <= '0;
      r_bin  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bcd  <= w_nbcd;
        r_bin  <= w_nbin;
        r_ovf  <= w_carry;
        r_cnt  <= CNT_W'(1);
        r_run  <= (DATA_W > 1);
        r_done <= (DATA_W == 1);
      end else if (r_run) begin
        r_bcd <= w_nbcd;
        r_bin <= w_nbin;
        r_ovf <= r_ovf | w_carry;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

// File: rtl/seg_scan_n.sv
// rtl/seg_scan_n.sv - multiplexed N-digit seven-segment driver with hex/decimal display
module seg_scan_n
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int SCAN_DIV    = 65536,
  parameter int UPDATE_DIV  = 2400000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic              clk_24m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              blank_lz,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig,
  output logic              busy,
  output logic              overflow
);

  localparam int DISP_W = 4 * DIGITS;
  localparam int UPD_W  = clog2(UPDATE_DIV);
  localparam int SCAN_W = clog2(SCAN_DIV);
  localparam int IDX_W  = clog2(DIGITS);
  localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  upd_state_e        r_state;
  logic [UPD_W-1:0]  r_upd_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_start;
  logic              r_busy;
  logic              r_ovf;
  logic              r_dash;
  logic [DISP_W-1:0] r_disp;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_dig;

  logic              w_upd_tick;
  logic              w_done;
  logic [DISP_W-1:0] w_bcd;
  logic              w_bcd_ovf;
  logic [DIGITS-1:0] w_onehot;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic              w_dp;
  logic              w_zero_above;
  logic [7:0]        w_pat;

  assign w_upd_tick = (r_upd_cnt == UPD_W'(UPDATE_DIV - 1));

  bcd_seq_conv #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .start   (r_start),
    .bin     (r_data),
    .done    (w_done),
    .bcd     (w_bcd),
    .ovf     (w_bcd_ovf)
  );

  // Ticks landing in ST_HEX or ST_DEC are dropped; the display only ever changes in one step.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_upd_cnt <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dash    <= 1'b0;
      r_disp    <= '0;
    end else begin
      r_upd_cnt <= w_upd_tick ? '0 : r_upd_cnt + 1'b1;
      r_start   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_upd_tick) begin
            r_data <= data_in;
            if (mode) begin
              r_state <= ST_DEC;
              r_busy  <= 1'b1;
              r_start <= 1'b1;
            end else begin
              r_state <= ST_HEX;
            end
          end
        end
        ST_HEX: begin
          r_disp  <= DISP_W'(r_data);
          r_dash  <= 1'b0;
          r_ovf   <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_DEC: begin
          if (w_done) begin
            r_disp  <= w_bcd;
            r_dash  <= w_bcd_ovf;
            r_ovf   <= w_bcd_ovf;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Scanning from the top digit down lets the zero run decide blanking in one pass.
  always_comb begin
    w_onehot     = '0;
    w_digit      = '0;
    w_blank      = 1'b0;
    w_dp         = 1'b0;
    w_zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above && (r_disp[4*k +: 4] == 4'd0);
      if (IDX_W'(k) == r_idx) begin
        w_onehot[k] = 1'b1;
        w_digit     = r_disp[4*k +: 4];
        w_blank     = blank_lz && w_zero_above && (k != 0);
        w_dp        = dp_in[k];
      end
    end
    w_pat = r_dash ? SEG_DASH : (w_blank ? SEG_BLANK : SEG_FONT[w_digit]);
    if (w_dp) w_pat[7] = 1'b0;
  end

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_seg      <= SEG_OFF;
      r_dig      <= DIG_OFF;
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      r_seg <= SEG_ACT_LOW ? w_pat : ~w_pat;
      r_dig <= DIG_ACT_LOW ? ~w_onehot : w_onehot;
    end
  end

  assign seg      = r_seg;
  assign dig      = r_dig;
  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seg_scan_n.sv
// tb/tb_seg_scan_n.sv - scoreboard bench for seg_scan_n (4 digits, fast scan and update)
module tb_seg_scan_n;

  logic        clk_24m;
  logic        rst_n;
  logic [15:0] data_in;
  logic        mode;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n;

  typedef struct packed {
    logic [31:0] segs;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_scan_n #(
    .DIGITS(4), .DATA_W(16), .SCAN_DIV(4), .UPDATE_DIV(64),
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk_24m  (clk_24m),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .mode     (mode),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dig      (dig),
    .busy     (busy),
    .overflow (overflow)
  );

  initial begin
    clk_24m = 1'b0;
    forever #20 clk_24m = ~clk_24m;
  end

  always @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic m,
                                 input logic [3:0] dp, input logic blz);
    exp_t       r;
    int         v;
    logic [3:0] dg [4];
    logic       nz;
    logic [7:0] s;
    v      = int'(d);
    r.ovf  = m && (v >= 10000);
    r.segs = '0;
    for (int k = 0; k < 4; k++) begin
      if (m) begin
        dg[k] = 4'(v % 10);
        v     = v / 10;
      end else begin
        dg[k] = d[4*k +: 4];
      end
    end
    nz = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (dg[k] != 4'd0) nz = 1'b1;
      if (r.ovf)                       s = 8'hBF;
      else if (blz && !nz && (k != 0)) s = 8'hFF;
      else                             s = FONT[dg[k]];
      if (dp[k]) s[7] = 1'b0;
      r.segs[8*k +: 8] = s;
    end
    return r;
  endfunction

  task automatic capture(output logic [31:0] got);
    logic [3:0] seen;
    logic [3:0] sel;
    seen = '0;
    got  = '0;
    repeat (20) begin
      @(negedge clk_24m);
      for (int k = 0; k < 4; k++) begin
        sel = 4'b0001 << k;
        if (dig == ~sel) begin
          got[8*k +: 8] = seg;
          seen[k]       = 1'b1;
        end
      end
    end
    check("scan_cover", 32'(seen), 32'hF);
  endtask

  task automatic measure_busy(input string tag);
    int t;
    t = 0;
    while (busy && t < 40) begin @(negedge clk_24m); t++; end
    t = 0;
    while (!busy && t < 80) begin @(negedge clk_24m); t++; end
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_tick_phase"}, 32'(edge_n % 64), 32'd0);
    t = 0;
    while (busy && t < 40) begin @(negedge clk_24m); t++; end
    check({tag, "_busy_len"}, 32'(t), 32'd17);
  endtask

  task automatic run_case(input string tag, input logic [15:0] d, input logic m,
                          input logic [3:0] dp, input logic blz, input bit conv);
    logic [31:0] got;
    exp_t        e;
    @(negedge clk_24m);
    data_in  = d;
    mode     = m;
    dp_in    = dp;
    blank_lz = blz;
    exp_q.push_back(model(d, m, dp, blz));
    if (conv) measure_busy(tag);
    else      repeat (72) @(negedge clk_24m);
    repeat (2) @(negedge clk_24m);
    capture(got);
    e = exp_q.pop_front();
    check({tag, "_segs"}, got, e.segs);
    check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
  endtask

  initial begin
    logic [3:0]  one;
    logic [3:0]  ed;
    logic [31:0] got;
    exp_t        e;
    int          t;

    rst_n    = 1'b0;
    data_in  = '0;
    mode     = 1'b0;
    dp_in    = '0;
    blank_lz = 1'b0;
    one      = 4'b0001;
    repeat (3) @(negedge clk_24m);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_dig", 32'(dig), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_24m);
      ed = ~(one << (i / 4));
      check("scan_dig", 32'(dig), 32'(ed));
      check("scan_seg", 32'(seg), 32'hC0);
    end

    run_case("hex_1a3f",   16'h1A3F, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_case("dec_1234",   16'd1234, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_case("dec_12345",  16'd12345, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_case("dec_42",     16'd42,   1'b1, 4'b0000, 1'b0, 1'b1);
    run_case("dec_9999",   16'd9999, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_case("dec_10000",  16'd10000, 1'b1, 4'b0000, 1'b1, 1'b1);
    run_case("lz_7",       16'd7,    1'b1, 4'b0000, 1'b1, 1'b1);
    run_case("lz_0",       16'd0,    1'b1, 4'b0000, 1'b1, 1'b1);
    run_case("lz_0_dp",    16'd0,    1'b1, 4'b0100, 1'b1, 1'b0);
    run_case("hex_lz_a0",  16'h00A0, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Abort a conversion in its fifth busy cycle.
    @(negedge clk_24m);
    data_in  = 16'd9999;
    mode     = 1'b1;
    dp_in    = '0;
    blank_lz = 1'b0;
    t = 0;
    while (busy && t < 40) begin @(negedge clk_24m); t++; end
    t = 0;
    while (!busy && t < 80) begin @(negedge clk_24m); t++; end
    check("abort_busy_rise", 32'(busy), 32'd1);
    repeat (4) @(negedge clk_24m);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_seg", 32'(seg), 32'hFF);
    check("abort_dig", 32'(dig), 32'hF);
    @(negedge clk_24m);
    rst_n = 1'b1;
    exp_q.push_back(model(16'd0, 1'b0, 4'b0000, 1'b0));
    capture(got);
    e = exp_q.pop_front();
    check("abort_segs", got, e.segs);
    check("abort_ovf_after", 32'(overflow), 32'(e.ovf));
    check("abort_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
